// File: rtl/key_note_ctrl.sv
// key_note_ctrl: keyboard front end for the piano.
// Synchronises and debounces eight keys (C5..C6), picks the lowest-numbered held key and
// drives the registered note index, one-hot enable, half-period count and a change pulse.
// A released note stays valid for SUSTAIN_CYCLES clocks before the output goes idle.
//
// Ports:
//   clk            system clock (50 MHz)
//   reset          asynchronous, active-high reset
//   keys_raw_i     raw buttons, bit 0 = C5 .. bit 7 = C6
//   note_valid_o   a note is playing or sustaining
//   note_idx_o     selected note index
//   note_onehot_o  one-hot of note_idx_o while note_valid_o, else 0
//   half_period_o  25000000/f for the selected note
//   note_change_o  single-clock pulse when a note starts or its index changes
//   keys_stable_o  debounced key state
module key_note_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SUSTAIN_CYCLES  = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  keys_raw_i,
  output logic        note_valid_o,
  output logic [2:0]  note_idx_o,
  output logic [7:0]  note_onehot_o,
  output logic [24:0] half_period_o,
  output logic        note_change_o,
  output logic [7:0]  keys_stable_o
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES);

  // The sustain counter only has to reach SUSTAIN_CYCLES-1 before leaving SUSTAIN.
  localparam int unsigned SusW = (SUSTAIN_CYCLES < 2) ? 1 : $clog2(SUSTAIN_CYCLES);
  localparam int unsigned SusLastInt = (SUSTAIN_CYCLES == 0) ? 0 : SUSTAIN_CYCLES - 1;
  localparam logic [SusW-1:0] SusLast = SusW'(SusLastInt);

  typedef enum logic [1:0] {StIdle, StPlay, StSustain} state_e;

  logic [7:0]           sync1_q, sync2_q;
  logic [7:0]           stable_q, stable_d;
  logic [7:0][DbW-1:0]  db_cnt_q, db_cnt_d;
  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [24:0]          half_period_q, half_period_d;
  logic                 change_q, change_d;
  logic [SusW-1:0]      sus_cnt_q, sus_cnt_d;
  logic                 any_key;
  logic [2:0]           prio_idx;

  function automatic logic [24:0] hp_lookup(input logic [2:0] idx);
    logic [24:0] hp;
    hp = 25'd47801;
    unique case (idx)
      3'd0: hp = 25'd47801;
      3'd1: hp = 25'd42589;
      3'd2: hp = 25'd37936;
      3'd3: hp = 25'd35816;
      3'd4: hp = 25'd31887;
      3'd5: hp = 25'd28409;
      3'd6: hp = 25'd25303;
      3'd7: hp = 25'd23877;
      default: hp = 25'd47801;
    endcase
    return hp;
  endfunction

  // Per-key debounce: a key flips only after the synced value has disagreed with the
  // stable value on DEBOUNCE_CYCLES+1 consecutive edges.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 8; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbLast) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end
    end
  end

  // Lowest set bit wins; scanning downwards leaves the lowest one as the final assignment.
  always_comb begin
    prio_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (stable_q[i]) prio_idx = 3'(i);
    end
  end

  assign any_key = |stable_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    change_d  = 1'b0;
    sus_cnt_d = sus_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_key) begin
          state_d  = StPlay;
          idx_d    = prio_idx;
          change_d = 1'b1;
        end
      end
      StPlay: begin
        if (any_key) begin
          if (prio_idx != idx_q) begin
            idx_d    = prio_idx;
            change_d = 1'b1;
          end
        end else if (SUSTAIN_CYCLES == 0) begin
          state_d = StIdle;
        end else begin
          state_d   = StSustain;
          sus_cnt_d = '0;
        end
      end
      StSustain: begin
        if (any_key) begin
          state_d = StPlay;
          if (prio_idx != idx_q) begin
            idx_d    = prio_idx;
            change_d = 1'b1;
          end
        end else if (sus_cnt_q == SusLast) begin
          state_d = StIdle;
        end else begin
          sus_cnt_d = sus_cnt_q + SusW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    half_period_d = hp_lookup(idx_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      db_cnt_q      <= '0;
      state_q       <= StIdle;
      idx_q         <= 3'd0;
      half_period_q <= 25'd47801;
      change_q      <= 1'b0;
      sus_cnt_q     <= '0;
    end else begin
      sync1_q       <= keys_raw_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      half_period_q <= half_period_d;
      change_q      <= change_d;
      sus_cnt_q     <= sus_cnt_d;
    end
  end

  assign note_valid_o  = (state_q != StIdle);
  assign note_idx_o    = idx_q;
  assign note_onehot_o = note_valid_o ? (8'b1 << idx_q) : 8'h00;
  assign half_period_o = half_period_q;
  assign note_change_o = change_q;
  assign keys_stable_o = stable_q;

endmodule

// File: tb/tb_key_note_ctrl.sv
// Self-checking bench for key_note_ctrl with DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=10.
// A behavioural model (run lengths, remaining-sustain countdown) predicts every output.
module tb_key_note_ctrl;

  localparam int unsigned Db  = 4;
  localparam int unsigned Sus = 10;
  localparam int unsigned HpTab [8] = '{47801, 42589, 37936, 35816, 31887, 28409, 25303, 23877};
  localparam logic [45:0] ResetObs = {1'b0, 3'd0, 8'h00, 25'd47801, 1'b0, 8'h00};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  keys_raw = 8'h00;
  logic        note_valid;
  logic [2:0]  note_idx;
  logic [7:0]  note_onehot;
  logic [24:0] half_period;
  logic        note_change;
  logic [7:0]  keys_stable;

  int n_checks = 0;
  int n_err = 0;

  key_note_ctrl #(
    .DEBOUNCE_CYCLES(Db),
    .SUSTAIN_CYCLES (Sus)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keys_raw_i   (keys_raw),
    .note_valid_o (note_valid),
    .note_idx_o   (note_idx),
    .note_onehot_o(note_onehot),
    .half_period_o(half_period),
    .note_change_o(note_change),
    .keys_stable_o(keys_stable)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_s1, m_s2, m_stable;
  int         m_run [8];
  int         m_mode;  // 0 silent, 1 playing, 2 sustaining
  int         m_rem;   // sustain clocks still to go
  logic [2:0] m_idx;
  logic       m_change;

  function automatic logic [2:0] low_idx(input logic [7:0] k);
    logic [7:0] lb;
    lb = k & (~k + 8'd1);
    return 3'($countones(lb - 8'd1));
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_mode = 0; m_rem = 0; m_idx = 3'd0;
    m_change = 1'b0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
  endtask

  task automatic model_clock(input logic [7:0] raw);
    logic       any;
    logic [2:0] p;
    any = |m_stable;
    p = low_idx(m_stable);
    m_change = 1'b0;
    if (m_mode == 0) begin
      if (any) begin m_mode = 1; m_idx = p; m_change = 1'b1; end
    end else if (any) begin
      m_mode = 1;
      if (p != m_idx) begin m_idx = p; m_change = 1'b1; end
    end else if (m_mode == 1) begin
      if (Sus == 0) m_mode = 0;
      else begin m_mode = 2; m_rem = Sus; end
    end else begin
      m_rem--;
      if (m_rem == 0) m_mode = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] > int'(Db)) begin m_stable[i] = m_s2[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  function automatic logic [45:0] exp_obs();
    logic v;
    v = (m_mode != 0);
    return {v, m_idx, v ? (8'b1 << m_idx) : 8'h00, 25'(HpTab[m_idx]), m_change, m_stable};
  endfunction

  function automatic logic [45:0] obs();
    return {note_valid, note_idx, note_onehot, half_period, note_change, keys_stable};
  endfunction

  // Drive inputs on the falling edge, advance the model on the rising edge, settle #1.
  task automatic step(input logic [7:0] raw, input logic rst);
    @(negedge clk);
    keys_raw = raw;
    reset = rst;
    @(posedge clk);
    if (rst) model_reset();
    else model_clock(raw);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int pulses;
    for (int c = 0; c < 3; c++) step(8'h00, 1'b1);
    n_checks++;
    if (obs() !== ResetObs) begin
      n_err++; $display("FAIL reset_init: got %h want %h", obs(), ResetObs);
    end
    for (int c = 0; c < 10; c++) begin
      step(8'h04, 1'b0);
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL reset_play cyc %0d: got %h want %h", c, obs(), exp_obs());
      end
    end
    n_checks++;
    if (note_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_play: note_valid got %b want 1", note_valid);
    end
    // Asynchronous assertion between edges.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs() !== ResetObs) begin
      n_err++; $display("FAIL reset_async: got %h want %h", obs(), ResetObs);
    end
    step(8'h04, 1'b1);
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      step(8'h04, 1'b0);
      if (note_change) pulses++;
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL reset_release cyc %0d: got %h want %h", c, obs(), exp_obs());
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_err++; $display("FAIL reset_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic go_idle(input string name);
    for (int c = 0; c < 25; c++) begin
      step(8'h00, 1'b0);
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL %s_idle cyc %0d: got %h want %h", name, c, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_single_key();
    int n;
    go_idle("single");
    step(8'h04, 1'b0);
    n = 0;
    while (keys_stable[2] !== 1'b1 && n < 20) begin
      step(8'h04, 1'b0);
      n++;
    end
    n_checks++;
    if (n != 6) begin
      n_err++; $display("FAIL single_debounce_latency: got %0d want 6", n);
    end
    step(8'h04, 1'b0);
    n_checks++;
    if ({note_valid, note_idx, half_period, note_onehot, note_change} !==
        {1'b1, 3'd2, 25'd37936, 8'h04, 1'b1}) begin
      n_err++;
      $display("FAIL single_outputs: got v=%b idx=%0d hp=%0d oh=%h chg=%b want 1 2 37936 04 1",
               note_valid, note_idx, half_period, note_onehot, note_change);
    end
    step(8'h04, 1'b0);
    n_checks++;
    if (note_change !== 1'b0) begin
      n_err++; $display("FAIL single_pulse_width: note_change got %b want 0", note_change);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] raw;
    go_idle("glitch");
    for (int c = 0; c < 18; c++) begin
      raw = (c < 3) ? 8'h20 : 8'h00;
      step(raw, 1'b0);
      n_checks++;
      if ({keys_stable, note_valid, note_change} !== 10'd0 || obs() !== exp_obs()) begin
        n_err++;
        $display("FAIL glitch cyc %0d: got stable=%h v=%b chg=%b want 00 0 0",
                 c, keys_stable, note_valid, note_change);
      end
    end
  endtask

  task automatic hold_window(input string name, input logic [7:0] raw, input int cycles,
                             output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      step(raw, 1'b0);
      if (note_change) pulses++;
      n_checks++;
      if (obs() !== exp_obs()) begin
        n_err++; $display("FAIL %s cyc %0d: got %h want %h", name, c, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_priority();
    int pulses;
    hold_window("prio_a5", 8'h20, 12, pulses);
    n_checks++;
    if ({note_idx, half_period} !== {3'd5, 25'd28409}) begin
      n_err++; $display("FAIL prio_a5: got idx=%0d hp=%0d want 5 28409", note_idx, half_period);
    end
    hold_window("prio_add", 8'h22, 12, pulses);
    n_checks++;
    if ({note_idx, half_period, pulses} !== {3'd1, 25'd42589, 32'd1}) begin
      n_err++;
      $display("FAIL prio_add: got idx=%0d hp=%0d pulses=%0d want 1 42589 1",
               note_idx, half_period, pulses);
    end
    hold_window("prio_rel", 8'h20, 12, pulses);
    n_checks++;
    if ({note_idx, pulses} !== {3'd5, 32'd1}) begin
      n_err++; $display("FAIL prio_rel: got idx=%0d pulses=%0d want 5 1", note_idx, pulses);
    end
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    step(8'h00, 1'b0);
    while (keys_stable !== 8'h00 && n < 20) begin
      step(8'h00, 1'b0);
      n++;
    end
    n_checks++;
    if (keys_stable !== 8'h00) begin
      n_err++; $display("FAIL %s_release_timeout: got stable=%h want 00", name, keys_stable);
    end
  endtask

  task automatic test_sustain_expiry();
    int pulses;
    int n;
    // 0x20 -> 0x80 swaps keys on the same edge; index follows the new set only.
    hold_window("sus_hold", 8'h80, 12, pulses);
    n_checks++;
    if ({note_idx, pulses} !== {3'd7, 32'd1}) begin
      n_err++; $display("FAIL sus_hold: got idx=%0d pulses=%0d want 7 1", note_idx, pulses);
    end
    wait_release("sus");
    n = 0;
    step(8'h00, 1'b0);
    while (note_valid === 1'b1 && n < 30) begin
      n_checks++;
      if (half_period !== 25'd23877 || obs() !== exp_obs()) begin
        n_err++; $display("FAIL sus_hp cyc %0d: got hp=%0d want 23877", n, half_period);
      end
      n++;
      step(8'h00, 1'b0);
    end
    n_checks++;
    if (n != 10) begin
      n_err++; $display("FAIL sus_length: got %0d want 10", n);
    end
    n_checks++;
    if ({note_valid, note_onehot} !== 9'd0) begin
      n_err++; $display("FAIL sus_end: got v=%b oh=%h want 0 00", note_valid, note_onehot);
    end
  endtask

  task automatic repress_window(input string name, input logic [7:0] raw, output int pulses);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      step(raw, 1'b0);
      if (note_change) pulses++;
      n_checks++;
      if (note_valid !== 1'b1 || obs() !== exp_obs()) begin
        n_err++; $display("FAIL %s cyc %0d: got %h want %h", name, c, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_sustain_repress();
    int pulses;
    hold_window("rep_hold", 8'h80, 12, pulses);
    wait_release("rep_same");
    repress_window("rep_same", 8'h80, pulses);
    n_checks++;
    if ({note_idx, pulses} !== {3'd7, 32'd0}) begin
      n_err++; $display("FAIL rep_same: got idx=%0d pulses=%0d want 7 0", note_idx, pulses);
    end
    wait_release("rep_diff");
    repress_window("rep_diff", 8'h08, pulses);
    n_checks++;
    if ({note_idx, half_period, pulses} !== {3'd3, 25'd35816, 32'd1}) begin
      n_err++;
      $display("FAIL rep_diff: got idx=%0d hp=%0d pulses=%0d want 3 35816 1",
               note_idx, half_period, pulses);
    end
  endtask

  task automatic test_random();
    logic [7:0] raw;
    int hold;
    int c;
    c = 0;
    while (c < 400) begin
      raw = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
      hold = int'($urandom_range(1, 9));
      for (int h = 0; h < hold; h++) begin
        step(raw, 1'b0);
        n_checks++;
        if (obs() !== exp_obs()) begin
          n_err++; $display("FAIL random cyc %0d: got %h want %h", c, obs(), exp_obs());
        end
        c++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_key();
    test_glitch();
    test_priority();
    test_sustain_expiry();
    test_sustain_repress();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_note_ctrl.md
# key_note_ctrl

Keyboard front end for the digital piano: synchronises and debounces eight push-button keys (C5..C6) and selects one active note by fixed priority. It emits a registered note index, a one-hot enable and the half-period count for that note, plus a short sustain after release. It sits directly upstream of the per-note square-wave generators and of any programmable tone divider. Those generators toggle their output every `half_period + 1` clocks of the 50 MHz system clock.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable clocks (10 ms) required before a key change is accepted; minimum 1.
- SUSTAIN_CYCLES, 5000000: clocks (100 ms) the last note stays valid after all keys are released; 0 means no sustain.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clock clk.
- keys_raw  in  8  raw buttons, active-high; bit 0 = C5, then D5, E5, F5, G5, A5, B5; bit 7 = C6.
- note_valid  out  1  a note is playing (PLAY or SUSTAIN).
- note_idx  out  3  index of the selected note (0..7).
- note_onehot  out  8  one bit set at note_idx when note_valid, else 0.
- half_period  out  25  half-period count `25000000/f`, truncated.
- note_change  out  1  one-clock pulse when a note starts or note_idx changes.
- keys_stable  out  8  debounced key state.

## Operation

- **Synchroniser:** two flip-flops per key, all bits in parallel.
- **Debounce (per key):** a counter of `ceil(log2(DEBOUNCE_CYCLES+1))` bits.
  - The counter clears whenever the synced bit equals the stable bit.
  - Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES, the stable bit takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes keys_stable.
- **Priority:** the lowest set bit of keys_stable wins. `any_key = |keys_stable`.
- **half_period lookup (25-bit constants):** 0=47801, 1=42589, 2=37936, 3=35816, 4=31887, 5=28409, 6=25303, 7=23877.
- **FSM states:** IDLE, PLAY, SUSTAIN.
  - **IDLE:** if any_key, go to PLAY, load note_idx = priority index, pulse note_change.
  - **PLAY:**
    - If any_key and the priority index differs from note_idx, reload note_idx and pulse note_change.
    - If !any_key, go to SUSTAIN with sustain counter = 0. If SUSTAIN_CYCLES = 0, go to IDLE instead.
  - **SUSTAIN:**
    - note_idx is held and the counter increments.
    - If any_key, go to PLAY. Pulse note_change only if the new index differs from the held one.
    - Else, when the counter reaches SUSTAIN_CYCLES-1, go to IDLE.
- **Output derivation:**
  - note_valid = (state != IDLE).
  - half_period is looked up from note_idx and is registered with it.
  - note_onehot = note_valid ? (1 << note_idx) : 0.
- **Reset values:** note_valid=0, note_idx=0, note_onehot=0, half_period=47801, note_change=0, keys_stable=0, all counters 0, state IDLE.
- **Reset mid-operation** returns to IDLE within the same clock edge (asynchronous). No note_change pulse is produced on reset release.

## Timing

- **Key to keys_stable:** a clean key edge at keys_raw appears on keys_stable DEBOUNCE_CYCLES+2 clocks after the first edge where the synced value differs. The extra 2 clocks are synchroniser latency.
- **keys_stable to outputs:** one clock. note_idx, note_onehot, half_period, note_valid and note_change all update on the same edge.
- **note_change** is high for exactly one clock per event. It is never asserted while the index is unchanged.
- **Simultaneous press and release** on the same cycle: the priority index is computed from the new keys_stable only.
- **SUSTAIN duration:** note_valid stays high for exactly SUSTAIN_CYCLES clocks after the PLAY→SUSTAIN edge, then drops.
- **Sustain counter** saturates safely: no wrap occurs before exit.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=10.

- **Reset:** assert reset mid-PLAY with keys_raw=8'h04 → all outputs at their reset values immediately. After release and debounce, note_change pulses once.
- **Single key:** press keys_raw=8'h04 cleanly → keys_stable[2] rises 6 clocks later. One clock after that: note_idx=2, half_period=37936, note_onehot=8'h04, one note_change pulse.
- **Glitch rejection:** 3-clock pulse on keys_raw[5] → keys_stable, note_valid and note_change all stay 0.
- **Priority:**
  - Hold 8'h20 (A5, note_idx=5, half_period=28409).
  - Add bit 1 → note_idx=1, half_period=42589, one note_change pulse.
  - Release bit 1 → note_idx=5, another pulse.
- **Sustain expiry:** release all keys from note 7 → note_valid high for 10 more clocks with half_period=23877, then 0 and note_onehot=0.
- **Sustain re-press:**
  - Re-press the same key during SUSTAIN → back to PLAY, no note_change pulse.
  - Press a different key during SUSTAIN → back to PLAY with the new index and one note_change pulse.
